// File: rtl/gpu_pkg.sv
// Shared GPU types: the packed draw instruction carried through the instruction queue
// and the screen/colour field widths it is built from.
package gpu_pkg;

    localparam int WIDTH_BITS   = 11;
    localparam int HEIGHT_BITS  = 10;
    localparam int CHANNEL_BITS = 8;

    typedef struct packed {
        logic [3:0]              opcode;
        logic [WIDTH_BITS-1:0]   x1;
        logic [HEIGHT_BITS-1:0]  y1;
        logic [WIDTH_BITS-1:0]   x2;
        logic [HEIGHT_BITS-1:0]  y2;
        logic [7:0]              rad;
        logic [CHANNEL_BITS-1:0] r;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] b;
        logic                    quad;
    } instr_t;

    localparam int INSTR_W = $bits(instr_t);

endpackage

// File: rtl/gpu_instruction_queue_if.sv
// Producer/consumer bundle around the instruction queue; master drives requests,
// slave is the queue side returning head data and status.
interface gpu_instruction_queue_if #(
    parameter int DATA_W = 79,
    parameter int DEPTH  = 8
);
    logic                     flush;
    logic                     push;
    logic [DATA_W-1:0]        data_in;
    logic                     pop;
    logic                     err_clr;
    logic [DATA_W-1:0]        data_out;
    logic                     empty;
    logic                     full;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output flush, push, data_in, pop, err_clr,
        input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, push, data_in, pop, err_clr,
        output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/gpu_fifo_mem.sv
// Queue storage: DEPTH x DATA_W register file, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module gpu_fifo_mem #(
    parameter int DATA_W = 79,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/gpu_instruction_queue.sv
// First-word-fall-through instruction FIFO with occupancy flags, flush and sticky
// overflow/underflow error flags.
module gpu_instruction_queue
    import gpu_pkg::*;
#(
    parameter int DATA_W     = INSTR_W,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    input  logic                     err_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              push_ok_s;
    logic              pop_ok_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic              is_empty_s;
    logic              is_full_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [DATA_W-1:0] rd_data_s;

    // accept/reject decisions and next occupancy
    always_comb begin
        is_empty_s  = (count_r == {CNT_W{1'b0}});
        is_full_s   = (count_r == DEPTH_C);
        pop_ok_s    = pop_i & ~flush_i & ~is_empty_s;
        // a pop in the same cycle frees the slot a full-queue push needs
        push_ok_s   = push_i & ~flush_i & (~is_full_s | pop_ok_s);
        ovf_set_s   = push_i & ~flush_i & is_full_s & ~pop_ok_s;
        unf_set_s   = pop_i & ~flush_i & is_empty_s;
        count_nxt_s = count_r;
        if (flush_i) begin
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // pointers, occupancy and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (flush_i) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
            // a new error wins over a simultaneous clear
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (err_clr_i) begin
                overflow_r <= 1'b0;
            end
            if (unf_set_s) begin
                underflow_r <= 1'b1;
            end else if (err_clr_i) begin
                underflow_r <= 1'b0;
            end
        end
    end

    gpu_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (push_ok_s),
        .waddr  (wr_ptr_r),
        .wdata  (data_i),
        .raddr  (rd_ptr_r),
        .rdata  (rd_data_s)
    );

    assign data_o         = is_empty_s ? {DATA_W{1'b0}} : rd_data_s;
    assign empty_o        = is_empty_s;
    assign full_o         = is_full_s;
    assign almost_full_o  = (count_r >= AFULL_C);
    assign almost_empty_o = (count_r <= AEMPTY_C);
    assign count_o        = count_r;
    assign overflow_o     = overflow_r;
    assign underflow_o    = underflow_r;

endmodule
